// File: rtl/sensor_conditioner_if.sv
// sensor_conditioner_if
//   Bundles the sensor-side bus of the conditioner: the raw asynchronous
//   sensor vectors for both bots and the debounced outputs with their
//   change strobes.
//   Ports (signals):
//     raw_sensors1, raw_sensors2 : 8-bit raw vectors (driven by master)
//     Sensors_reg1, Sensors_reg2 : 8-bit debounced vectors (driven by slave)
//     change1, change2           : one-cycle update strobes (driven by slave)
//   Modports:
//     master : the environment that supplies raw data and consumes results
//     slave  : the conditioner itself
interface sensor_conditioner_if;
    logic [7:0] raw_sensors1;
    logic [7:0] raw_sensors2;
    logic [7:0] Sensors_reg1;
    logic [7:0] Sensors_reg2;
    logic       change1;
    logic       change2;

    modport master (
        output raw_sensors1,
        output raw_sensors2,
        input  Sensors_reg1,
        input  Sensors_reg2,
        input  change1,
        input  change2
    );

    modport slave (
        input  raw_sensors1,
        input  raw_sensors2,
        output Sensors_reg1,
        output Sensors_reg2,
        output change1,
        output change2
    );
endinterface

// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Front end of the scoreboard. For each of two bots it double-flop
//   synchronises the raw 8-bit sensor vector, debounces the whole vector
//   (any bit difference counts as instability) and drives a clean output
//   plus a one-cycle strobe whenever that output updates. map_rst returns
//   both channels to IDLE_VALUE so no stale hits survive a map change.
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles needed to accept a new value (2..255)
//     IDLE_VALUE      : value after reset / map_rst ("no hit" pattern)
//   Ports:
//     clk         : system clock, rising edge
//     board_rst_n : asynchronous active-low reset
//     map_rst     : synchronous active-high channel clear
//     bus         : slave side of sensor_conditioner_if (raw in, clean out)
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 8,
    parameter logic [7:0] IDLE_VALUE      = 8'h07
) (
    input  logic                  clk,
    input  logic                  board_rst_n,
    input  logic                  map_rst,
    sensor_conditioner_if.slave   bus
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0][DATA_W-1:0] raw;
    logic [1:0][DATA_W-1:0] sens;
    logic [1:0]             strobe;

    assign raw[0] = bus.raw_sensors1;
    assign raw[1] = bus.raw_sensors2;

    assign bus.Sensors_reg1 = sens[0];
    assign bus.Sensors_reg2 = sens[1];
    assign bus.change1      = strobe[0];
    assign bus.change2      = strobe[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
        logic [DATA_W-1:0] cand;
        logic [DATA_W-1:0] out;
        logic [CNT_W-1:0]  cnt;
        logic              chg;

        // The channel is PENDING whenever cand differs from out; cnt counts
        // consecutive edges on which s2 has matched cand. STABLE is simply
        // cand == out, so no separate state register is needed.
        always_ff @(posedge clk or negedge board_rst_n) begin
            if (!board_rst_n) begin
                s1   <= IDLE_VALUE;
                s2   <= IDLE_VALUE;
                cand <= IDLE_VALUE;
                out  <= IDLE_VALUE;
                cnt  <= '0;
                chg  <= 1'b0;
            end else if (map_rst) begin
                // Clears the synchroniser too, so a value still on raw needs
                // the full synchroniser + debounce latency to come back.
                s1   <= IDLE_VALUE;
                s2   <= IDLE_VALUE;
                cand <= IDLE_VALUE;
                out  <= IDLE_VALUE;
                cnt  <= '0;
                chg  <= 1'b0;
            end else begin
                s1  <= raw[c];
                s2  <= s1;
                chg <= 1'b0;
                if (s2 != cand) begin
                    // New candidate: restart the stability count.
                    cand <= s2;
                    cnt  <= '0;
                end else if (cand == out) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    // Terminal count: accept the candidate and strobe.
                    out <= cand;
                    chg <= 1'b1;
                    cnt <= '0;
                end
            end
        end

        assign sens[c]   = out;
        assign strobe[c] = chg;
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner
//   Directed self-checking bench for sensor_conditioner with the default
//   parameters (DEBOUNCE_CYCLES = 8, IDLE_VALUE = 8'h07). Inputs change on
//   the falling edge; outputs are sampled 1 time unit after the rising edge.
//   With raw changed before tick 1 (k = 1), the update lands at tick 11.
module tb_sensor_conditioner;
    logic clk = 1'b0;
    logic board_rst_n;
    logic map_rst;

    int passed = 0;
    int total  = 0;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .IDLE_VALUE      (8'h07)
    ) dut (
        .clk         (clk),
        .board_rst_n (board_rst_n),
        .map_rst     (map_rst),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both raw inputs and let the channels settle (no checks here).
    task automatic settle(input logic [7:0] v1, input logic [7:0] v2);
        @(negedge clk);
        bus.raw_sensors1 = v1;
        bus.raw_sensors2 = v2;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        board_rst_n      = 1'b0;
        map_rst          = 1'b0;
        bus.raw_sensors1 = 8'hAA;
        bus.raw_sensors2 = 8'hAA;
        repeat (2) tick();
        total++;
        if (bus.Sensors_reg1 !== 8'h07) $display("FAIL reset_out1: got %h expected %h", bus.Sensors_reg1, 8'h07);
        else passed++;
        total++;
        if (bus.Sensors_reg2 !== 8'h07) $display("FAIL reset_out2: got %h expected %h", bus.Sensors_reg2, 8'h07);
        else passed++;
        total++;
        if (bus.change1 !== 1'b0) $display("FAIL reset_chg1: got %b expected 0", bus.change1);
        else passed++;
        total++;
        if (bus.change2 !== 1'b0) $display("FAIL reset_chg2: got %b expected 0", bus.change2);
        else passed++;

        @(negedge clk);
        board_rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            logic [7:0] exp_out;
            logic       exp_chg;
            tick();
            exp_out = (i >= 11) ? 8'hAA : 8'h07;
            exp_chg = (i == 11);
            total++;
            if (bus.Sensors_reg1 !== exp_out || bus.change1 !== exp_chg)
                $display("FAIL release_ch1 tick %0d: got %h/%b expected %h/%b", i, bus.Sensors_reg1, bus.change1, exp_out, exp_chg);
            else passed++;
            total++;
            if (bus.Sensors_reg2 !== exp_out || bus.change2 !== exp_chg)
                $display("FAIL release_ch2 tick %0d: got %h/%b expected %h/%b", i, bus.Sensors_reg2, bus.change2, exp_out, exp_chg);
            else passed++;
        end
    endtask

    task automatic test_clean_hit();
        settle(8'h07, 8'h07);
        @(negedge clk);
        bus.raw_sensors1 = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            logic [7:0] exp_out;
            logic       exp_chg;
            tick();
            exp_out = (i >= 11) ? 8'h00 : 8'h07;
            exp_chg = (i == 11);
            total++;
            if (bus.Sensors_reg1 !== exp_out || bus.change1 !== exp_chg)
                $display("FAIL hit_ch1 tick %0d: got %h/%b expected %h/%b", i, bus.Sensors_reg1, bus.change1, exp_out, exp_chg);
            else passed++;
            total++;
            if (bus.Sensors_reg2 !== 8'h07 || bus.change2 !== 1'b0)
                $display("FAIL hit_ch2_quiet tick %0d: got %h/%b expected 07/0", i, bus.Sensors_reg2, bus.change2);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            bus.raw_sensors2 = (i <= 5) ? 8'h00 : 8'h07;
            tick();
            total++;
            if (bus.Sensors_reg2 !== 8'h07 || bus.change2 !== 1'b0)
                $display("FAIL glitch_ch2 tick %0d: got %h/%b expected 07/0", i, bus.Sensors_reg2, bus.change2);
            else passed++;
            total++;
            if (bus.Sensors_reg1 !== 8'h00 || bus.change1 !== 1'b0)
                $display("FAIL glitch_ch1_hold tick %0d: got %h/%b expected 00/0", i, bus.Sensors_reg1, bus.change1);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        settle(8'h07, 8'h07);
        // Ten 3-cycle phases starting at 00 (last phase is 07), then hold 00.
        // The final transition is sampled at tick 31, so the strobe is at 41.
        for (int i = 1; i <= 50; i++) begin
            logic [7:0] exp_out;
            logic       exp_chg;
            @(negedge clk);
            if (i <= 30) bus.raw_sensors1 = (((i - 1) / 3) % 2 == 0) ? 8'h00 : 8'h07;
            else         bus.raw_sensors1 = 8'h00;
            tick();
            exp_out = (i >= 41) ? 8'h00 : 8'h07;
            exp_chg = (i == 41);
            total++;
            if (bus.Sensors_reg1 !== exp_out || bus.change1 !== exp_chg)
                $display("FAIL bounce_ch1 tick %0d: got %h/%b expected %h/%b", i, bus.Sensors_reg1, bus.change1, exp_out, exp_chg);
            else passed++;
        end
    endtask

    task automatic test_map_rst_mid();
        settle(8'h07, 8'h07);
        // raw sampled at tick 1, cand at tick 3, cnt == 4 when tick 8 samples.
        for (int i = 1; i <= 22; i++) begin
            logic [7:0] exp_out;
            logic       exp_chg;
            @(negedge clk);
            bus.raw_sensors1 = 8'h00;
            map_rst = (i == 8);
            tick();
            exp_out = (i >= 19) ? 8'h00 : 8'h07;
            exp_chg = (i == 19);
            total++;
            if (bus.Sensors_reg1 !== exp_out || bus.change1 !== exp_chg)
                $display("FAIL map_mid_ch1 tick %0d: got %h/%b expected %h/%b", i, bus.Sensors_reg1, bus.change1, exp_out, exp_chg);
            else passed++;
        end
        @(negedge clk);
        map_rst = 1'b0;
    endtask

    task automatic test_map_rst_terminal();
        // out1 is 00; raw back to 07 would strobe at tick 11, map_rst there wins.
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_out;
            @(negedge clk);
            bus.raw_sensors1 = 8'h07;
            map_rst = (i == 11);
            tick();
            exp_out = (i >= 11) ? 8'h07 : 8'h00;
            total++;
            if (bus.Sensors_reg1 !== exp_out || bus.change1 !== 1'b0)
                $display("FAIL map_term_ch1 tick %0d: got %h/%b expected %h/0", i, bus.Sensors_reg1, bus.change1, exp_out);
            else passed++;
        end
        @(negedge clk);
        map_rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        settle(8'h07, 8'h07);
        @(negedge clk);
        bus.raw_sensors1 = 8'h01;
        bus.raw_sensors2 = 8'h02;
        for (int i = 1; i <= 14; i++) begin
            logic exp_chg;
            tick();
            exp_chg = (i == 11);
            total++;
            if (bus.change1 !== exp_chg || bus.change2 !== exp_chg)
                $display("FAIL simul_chg tick %0d: got %b%b expected %b%b", i, bus.change1, bus.change2, exp_chg, exp_chg);
            else passed++;
            total++;
            if (bus.Sensors_reg1 !== ((i >= 11) ? 8'h01 : 8'h07) || bus.Sensors_reg2 !== ((i >= 11) ? 8'h02 : 8'h07))
                $display("FAIL simul_out tick %0d: got %h/%h expected %h/%h", i, bus.Sensors_reg1, bus.Sensors_reg2,
                         (i >= 11) ? 8'h01 : 8'h07, (i >= 11) ? 8'h02 : 8'h07);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_hit();
        test_glitch();
        test_bounce();
        test_map_rst_mid();
        test_map_rst_terminal();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
